mod_updown_counter: RTL
=======================

// Module: mod_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter for the datapath timing and sequencing blocks.
//  Adds the following over the plain 4-bit up counter:
//   - generic width and modulus, direction control, synchronous load and clear;
//   - wrap or saturate mode per cycle, boundary-event pulse, sticky over/underflow flags;
//   - optional even-parity tag on the count.
// PARAMETERS
//  WIDTH    4   counter width in bits; legal range 2..32
//  MODULUS  16  count range is 0..MODULUS-1; legal range 2..2**WIDTH
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high; forces all state to reset values
//  clear       in   1      synchronous clear of count and both sticky flags
//  load        in   1      synchronous load of load_value
//  load_value  in   WIDTH  value to load; clamped to MODULUS-1 if larger
//  enable      in   1      step count by one this cycle
//  up_down     in   1      1 = increment, 0 = decrement
//  sat_mode    in   1      0 = wrap at boundaries, 1 = hold at boundaries
//  clear_flags in   1      synchronous clear of overflow/underflow
//  count       out  WIDTH  current count, registered
//  tc          out  1      1-cycle registered pulse on a boundary event
//  overflow    out  1      sticky: an increment was attempted at MODULUS-1
//  underflow   out  1      sticky: a decrement was attempted at 0
//  parity      out  1      even parity of count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: count=0, tc=0, overflow=0, underflow=0, parity=0. Reset is honoured mid-operation.
//  - All outputs are registered. A change is visible one clk after the sampling edge; there is no combinational path from input to output.
//  - Per-cycle priority is clear > load > enable. With none of them asserted, count holds and tc=0.
//  - clear: count<=0, overflow<=0, underflow<=0, tc<=0. Overrides load and enable in the same cycle.
//  - load: count <= min(load_value, MODULUS-1). tc<=0. Flags are unchanged. load and enable in the same cycle: load wins and no step occurs.
//  - enable, up, count<MODULUS-1: count+1.
//  - enable, up, count==MODULUS-1 (boundary event):
//    - sat_mode=0: count<=0.
//    - sat_mode=1: count holds.
//    - In both modes: tc<=1 and overflow<=1.
//  - enable, down, count>0: count-1.
//  - enable, down, count==0 (boundary event):
//    - sat_mode=0: count<=MODULUS-1.
//    - sat_mode=1: count holds.
//    - In both modes: tc<=1 and underflow<=1.
//  - tc is high for exactly the one cycle after the boundary step. Back-to-back boundary steps (saturated, enable held) keep tc high every cycle.
//  - Arithmetic is done at WIDTH+1 bits internally, so MODULUS=2**WIDTH wraps correctly with no truncation hazard.
//  - clear_flags with a new over/underflow in the same cycle: set wins and the flag reads 1.
//  - clear_flags alone: both flags go to 0 next cycle. count and tc are unaffected.
//  - sat_mode and up_down may change every cycle. They are sampled only when enable is high.
// CONFIGURATION
//  - COUNTER_PARITY_EN defined:
//    - parity is a register updated with ^next_count, so it is always coherent with count in the same cycle.
//    - Reset and clear give parity=0.
//  - COUNTER_PARITY_EN undefined:
//    - parity is tied to 1'b0 and no parity flop exists.
//    - The port list is identical in both builds.
// STRUCTURE
//  - Package counter_pkg holds:
//    - localparams DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1;
//    - function clamp_load(value, modulus).
//  - One sub-module, mod_counter_next (combinational). Inputs: count, up_down, sat_mode, MODULUS. Outputs: next_count, ovf_evt, unf_evt.
//  - The top level holds the priority mux, the registers and the sticky flags.
// TESTING
//  All scenarios use WIDTH=4, MODULUS=10 unless stated otherwise.
//  1. Reset: assert reset mid-count at count=7 -> count=0, tc=0, flags=0 immediately, without waiting for clk.
//  2. Up wrap: enable=1, up, sat_mode=0, from 0 for 10 cycles -> count 1..9 then 0. tc high only on the cycle count shows 0. overflow=1 stays set.
//  3. Down saturate: load 0, enable, down, sat_mode=1 for 3 cycles -> count stays 0, tc=1 every cycle, underflow=1.
//  4. Load and priority:
//     - load_value=13 -> count=9 (clamped).
//     - load and enable together -> loaded value, no step.
//     - clear, load and enable together -> count=0.
//  5. Flag race: clear_flags in the same cycle as the 9->0 wrap -> overflow=1. clear_flags on the next cycle alone -> overflow=0.
//  6. Full range, WIDTH=4, MODULUS=16:
//     - up from 15 -> 0 with tc.
//     - With COUNTER_PARITY_EN defined, parity==^count on every cycle across the full sweep.
//     - Without the macro, parity stays 0 throughout.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and the load-clamp helper for the modulo-N up/down counter.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // 33-bit operands cover WIDTH up to 32 with MODULUS up to 2**32.
  function automatic logic [32:0] clamp_load(input logic [32:0] value, input logic [32:0] modulus);
    logic [32:0] max_val;
    max_val = modulus - 33'd1;
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational step logic: next count and boundary events for one enabled step.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter longint      MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_evt,
  output logic             unf_evt
);

  // One extra bit so MODULUS == 2**WIDTH compares without truncation.
  localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] count_ext;
  assign count_ext = {1'b0, count};

  always_comb begin
    next_count = count;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (up_down == DIR_UP) begin
      if (count_ext == MAX_VAL) begin
        ovf_evt = 1'b1;
        if (sat_mode == MODE_WRAP) next_count = '0;
      end else begin
        next_count = WIDTH'(count_ext + (WIDTH+1)'(1));
      end
    end else begin
      if (count_ext == '0) begin
        unf_evt = 1'b1;
        if (sat_mode == MODE_WRAP) next_count = WIDTH'(MAX_VAL);
      end else begin
        next_count = WIDTH'(count_ext - (WIDTH+1)'(1));
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load/clear, wrap/saturate, tc pulse and sticky flags.
// Optional registered even-parity output when COUNTER_PARITY_EN is defined.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow,
  output logic             parity
);

  logic [WIDTH-1:0] step_count;
  logic             ovf_evt;
  logic             unf_evt;

  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             overflow_d;
  logic             underflow_d;

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count),
    .up_down    (up_down),
    .sat_mode   (sat_mode),
    .next_count (step_count),
    .ovf_evt    (ovf_evt),
    .unf_evt    (unf_evt)
  );

  // clear > load > enable; a new event outranks clear_flags on the sticky flags.
  always_comb begin
    count_d     = count;
    tc_d        = 1'b0;
    overflow_d  = overflow & ~clear_flags;
    underflow_d = underflow & ~clear_flags;
    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (load) begin
      count_d = WIDTH'(clamp_load({{(33-WIDTH){1'b0}}, load_value}, 33'(MODULUS)));
    end else if (enable) begin
      count_d = step_count;
      tc_d    = ovf_evt | unf_evt;
      if (ovf_evt) overflow_d  = 1'b1;
      if (unf_evt) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      tc        <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_d;
      tc        <= tc_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

`ifdef COUNTER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ^count_d;
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

endmodule
